// File: rtl/ate_stream.sv
// Adaptive threshold engine: splits a pixel stream into blocks and computes one threshold per block.
// Each finished block is binarised against its own threshold while the next block is being received.
module ate_stream #(
  parameter int PIX_W        = 8,
  parameter int BLK_SIZE     = 64,
  parameter int BLKS_PER_ROW = 6,
  parameter int BORDER_L     = 2,
  parameter int BORDER_R     = 0,
  parameter int MIN_CONTRAST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             mode,
  output logic             out_valid,
  output logic             bin,
  output logic [PIX_W-1:0] threshold
);

  localparam int IW = $clog2(BLK_SIZE);
  localparam int CW = (BLKS_PER_ROW > 1) ? $clog2(BLKS_PER_ROW) : 1;
  localparam int SW = PIX_W + IW;
  localparam logic [IW-1:0] IDX_LAST = IW'(BLK_SIZE - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(BLKS_PER_ROW - 1);

  logic [PIX_W-1:0] blk_buf [BLK_SIZE];

  logic [IW-1:0]    idx;
  logic [CW-1:0]    col;
  logic [PIX_W-1:0] mn, mx;
  logic [SW-1:0]    sum;
  logic             mode_l;
  logic             buf_vld;
  logic [PIX_W-1:0] thr_cur;
  logic             flat;
  logic             border;

  logic             first, last;
  logic [PIX_W-1:0] old_pix;
  logic [PIX_W-1:0] mn_n, mx_n, rng;
  logic [SW-1:0]    sum_n, mean_sum;
  logic [PIX_W:0]   mid_sum;
  logic [PIX_W-1:0] stat;
  logic             flat_n, border_n;

  always_comb begin
    first   = (idx == '0);
    last    = (idx == IDX_LAST);
    old_pix = blk_buf[idx];
    if (first) begin
      mn_n  = pix_data;
      mx_n  = pix_data;
      sum_n = SW'(pix_data);
    end else begin
      mn_n  = (pix_data < mn) ? pix_data : mn;
      mx_n  = (pix_data > mx) ? pix_data : mx;
      sum_n = sum + SW'(pix_data);
    end
    // completion never coincides with idx==0, so the latched mode is the block's mode
    mid_sum  = {1'b0, mn_n} + {1'b0, mx_n} + (PIX_W+1)'(1);
    mean_sum = sum_n + SW'(BLK_SIZE / 2);
    stat     = mode_l ? PIX_W'(mean_sum >> IW) : PIX_W'(mid_sum >> 1);
    rng      = mx_n - mn_n;
    flat_n   = (int'(rng) < MIN_CONTRAST);
    border_n = (int'(col) < BORDER_L) || (int'(col) >= BLKS_PER_ROW - BORDER_R);
  end

  // read-before-write: old_pix is taken combinationally from the same slot being overwritten
  always_ff @(posedge clk) begin
    if (in_valid) blk_buf[idx] <= pix_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx       <= '0;
      col       <= '0;
      mn        <= '0;
      mx        <= '0;
      sum       <= '0;
      mode_l    <= 1'b0;
      buf_vld   <= 1'b0;
      thr_cur   <= '0;
      flat      <= 1'b0;
      border    <= 1'b0;
      out_valid <= 1'b0;
      bin       <= 1'b0;
    end else begin
      out_valid <= in_valid && buf_vld;
      bin       <= in_valid && buf_vld && !border && !flat && (old_pix >= thr_cur);
      if (in_valid) begin
        idx <= idx + 1'b1;
        mn  <= mn_n;
        mx  <= mx_n;
        sum <= sum_n;
        if (first) mode_l <= mode;
        if (last) begin
          thr_cur <= stat;
          flat    <= flat_n;
          border  <= border_n;
          buf_vld <= 1'b1;
          col     <= (col == COL_LAST) ? '0 : col + 1'b1;
        end
      end
    end
  end

  assign threshold = border ? '0 : thr_cur;

endmodule

// File: doc/ate_stream.md
Name: ate_stream

Overview:
- Parametrised successor to the fixed 64-pixel adaptive threshold engine.
- Takes a pixel stream with a valid qualifier and splits it into blocks of BLK_SIZE pixels, BLKS_PER_ROW blocks per row.
- Computes one threshold per block (midrange or mean, selectable) and emits a 1-bit binarised stream of each block while the next block is being received.
- Sits between the pixel source and the binary-image writer.

Parameters:
PIX_W, 8, pixel and threshold width in bits.
BLK_SIZE, 64, pixels per block; power of two, at least 2.
BLKS_PER_ROW, 6, blocks per image row.
BORDER_L, 2, leading block columns per row forced to bin=0 and threshold=0.
BORDER_R, 0, trailing block columns per row forced to bin=0 and threshold=0.
MIN_CONTRAST, 0, a block with (max-min) < MIN_CONTRAST is "flat"; all its bins are 0.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous active-low reset.
in_valid  input  1  pix_data is accepted this cycle.
pix_data  input  PIX_W  incoming pixel.
mode  input  1  0 = midrange, 1 = mean; sampled when the first pixel of a block is accepted.
out_valid  output  1  bin is valid this cycle.
bin  output  1  binarised pixel of the previous block.
threshold  output  PIX_W  threshold applied to the block currently being output.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Clears idx, column counter, min, max, sum, the buffer-valid flag, threshold, bin and out_valid.
  - Buffer contents need not be cleared.
  - Takes effect mid-block. The next block accepted after reset produces no output.
- Accept: a pixel is accepted on any cycle with in_valid=1. There is no backpressure; the block never stalls the source.
- idx (log2 BLK_SIZE bits):
  - Increments per accepted pixel and wraps BLK_SIZE-1 -> 0.
  - The accept with idx==BLK_SIZE-1 is block completion.
- Column counter:
  - Increments on each block completion and wraps BLKS_PER_ROW-1 -> 0.
  - Tracks the column of the block being received; the output block is the previous column, with wrap.
- Buffer: one BLK_SIZE x PIX_W array. On each accept, read buf[idx] (old block) and write pix_data into buf[idx] in the same cycle (read-before-write).
- Statistics:
  - When idx==0 is accepted, reload min=max=pix_data and sum=pix_data, and latch mode.
  - Otherwise update min, max and sum (width PIX_W+log2 BLK_SIZE) with the accepted pixel.
- Block completion: compute stat from the final values, including the completing pixel.
  - Midrange: (min+max+1)>>1, evaluated at PIX_W+1 bits.
  - Mean: (sum+BLK_SIZE/2)>>log2(BLK_SIZE), round half up.
  - Result fits PIX_W bits.
  - Register, for the block just completed: thr_cur <= stat, flat flag <= (max-min < MIN_CONTRAST), border flag from its column, buffer-valid <= 1.
  - threshold output = 0 if border, else thr_cur.
  - Register updates become visible on the cycle after the completing accept and hold for the whole next block.
- Output (registered, latency 1):
  - On the cycle after each accept with buffer-valid=1, out_valid=1.
  - bin = !border && !flat && (old_pixel >= thr_cur).
  - Otherwise out_valid=0 and bin=0.
- Stalls: gaps in in_valid produce matching gaps in out_valid. The bin sequence equals that of a gap-free run.
- Simultaneous events: on a completing accept, the output for the last pixel of the previous block uses the old thr_cur and flags; the new values apply from the next accept.
- mode changes mid-block are ignored until the next idx==0 accept.
- Outputs are never X after reset is released.

Test Plan:
- Threshold value (defaults, mode=0): feed 2 border blocks, then column 2 ramp 0..63, then any column 3 block -> threshold=32 from the cycle after ramp completion. During column 3 input, bins for j=0..31 are 0 and j=32..63 are 1, each out_valid one cycle after its accept.
- Mean mode (mode=1, column 2): 63 pixels of 10 plus one 74, sum=704 -> threshold=11. Exactly one bin=1, at the index of 74.
- Border and row wrap (defaults): stream 8 blocks of 200 -> output blocks for columns 0 and 1 have threshold=0 and bin=0, columns 2..5 have bin=1. Column 0 of the next row has threshold=0 and bin=0 again.
- Stalls: repeat the first scenario with in_valid toggling 1,0,0,1... -> out_valid follows each accept by exactly 1 cycle. The bin sequence is identical.
- Flat block (MIN_CONTRAST=8): a column-2 block with values 100..105 -> threshold=103 and all 64 bins 0. A following block with 0/255 values outputs normally.
- Reset mid-operation: drive reset=0 at idx=20 of block 3 -> next cycle out_valid=0, threshold=0. After release, the first 64 accepted pixels give out_valid=0 throughout, and output resumes on the second block.
